// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types, exception codes and byte-rotate helpers for the data-memory responder
`timescale 1ns/1ps
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dmem_state_t;

    localparam logic [3:0] EXC_LOAD_ACCESS_FAULT  = 4'd5;
    localparam logic [3:0] EXC_STORE_ACCESS_FAULT = 4'd7;

    // Rotate by whole bytes; a shift of 32 yields 0, so off=0 passes the word through.
    function automatic logic [31:0] rotr(input logic [31:0] w, input logic [1:0] off);
        logic [5:0] sh;
        sh = {1'b0, off, 3'b000};
        return (w >> sh) | (w << (6'd32 - sh));
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] w, input logic [1:0] off);
        logic [5:0] sh;
        sh = {1'b0, off, 3'b000};
        return (w << sh) | (w >> (6'd32 - sh));
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// rtl/dmem_sram_array.sv - DEPTH x 32 storage with one synchronous read port and one write port
`timescale 1ns/1ps
module dmem_sram_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory slave returning byte-rotated words
// Optional DMEM_BOUNDS_CHECK_EN: out-of-range indices fault instead of wrapping modulo DEPTH.
`timescale 1ns/1ps
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_data_sig,
    output logic [31:0] read_data,
    output logic        wait_sig,
    output logic        access_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t   state, next_state;
    logic [CW-1:0] cnt;
    logic [31:0]   addr_q;
    logic          store_q;
    logic          in_range;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_in;
    logic [AW-1:0] rd_addr;
    logic [31:0]   sram_rd_data;
    logic          sram_we;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_range = (addr_q[31:2] < 30'(DEPTH));
    assign idx_q    = addr_q[AW+1:2];
    assign idx_in   = address[AW+1:2];
`else
    assign in_range = 1'b1;
    assign idx_q    = AW'(addr_q[31:2] % 30'(DEPTH));
    assign idx_in   = AW'(address[31:2] % 30'(DEPTH));
`endif

    // The array read is launched from IDLE so data is ready in the first READ cycle even at LATENCY=1.
    assign rd_addr = (state == IDLE) ? idx_in : idx_q;
    assign sram_we = (state == WRITE) && in_range;

    dmem_sram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (sram_rd_data),
        .we      (sram_we),
        .wr_addr (idx_q),
        .wr_data (rotl(write_data, addr_q[1:0]))
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        wait_sig   = 1'b0;
        case (state)
            IDLE: begin
                wait_sig = access_en;
                if (access_en) begin
                    next_state = READ;
                end
            end
            READ: begin
                wait_sig = 1'b1;
                if (cnt == '0) begin
                    next_state = store_q ? WRITE : DONE;
                end
            end
            WRITE: begin
                wait_sig   = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (rst) begin
            wait_sig = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            addr_q       <= '0;
            store_q      <= 1'b0;
            read_data    <= '0;
            access_fault <= 1'b0;
        end else begin
            access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (access_en) begin
                        addr_q  <= address;
                        store_q <= write_data_sig;
                        cnt     <= CW'(LATENCY - 1);
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        read_data    <= in_range ? rotr(sram_rd_data, addr_q[1:0]) : '0;
                        access_fault <= !store_q && !in_range;
                    end
                end
                WRITE: begin
                    access_fault <= !in_range;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
